// File: rtl/inv_butterfly_pipe.sv
// rtl/inv_butterfly_pipe.sv - two-stage inverse radix-2 butterfly with valid/ready flow control and frame counting
module inv_butterfly_pipe #(
  parameter int W          = 12,
  parameter int FRAME_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2*W-1:0]        C1,
  input  logic [2*W-1:0]        C2,
  output logic [2*W-1:0]        A,
  output logic [2*W-1:0]        B,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [FRAME_LOG2-1:0] frame_cnt,
  output logic                  frame_done
);

  localparam logic [FRAME_LOG2-1:0] CNT_MAX = '1;

  logic         s1_valid;
  logic [W:0]   s1_ar;
  logic [W:0]   s1_ai;
  logic [W:0]   s1_br;
  logic [W:0]   s1_bi;
  logic         s2_load;
  logic         s1_load;
  logic         out_xfer;

  logic [W:0]   c1_r;
  logic [W:0]   c1_i;
  logic [W:0]   c2_r;
  logic [W:0]   c2_i;

  // One guard bit keeps the full sum/difference before the halving shift.
  assign c1_r = {C1[2*W-1], C1[2*W-1:W]};
  assign c1_i = {C1[W-1],   C1[W-1:0]};
  assign c2_r = {C2[2*W-1], C2[2*W-1:W]};
  assign c2_i = {C2[W-1],   C2[W-1:0]};

  assign s2_load  = !out_valid || out_ready;
  assign s1_load  = !s1_valid || s2_load;
  assign in_ready = s1_load;
  assign out_xfer = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_ar    <= '0;
      s1_ai    <= '0;
      s1_br    <= '0;
      s1_bi    <= '0;
    end else if (s1_load) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_ar <= c1_r + c2_r;
        s1_ai <= c1_i + c2_i;
        s1_br <= c1_r - c2_r;
        s1_bi <= c1_i - c2_i;
      end
    end
  end

  // Dropping bit 0 of the W+1-bit value is the arithmetic shift right by one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      A         <= '0;
      B         <= '0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        A <= {s1_ar[W:1], s1_ai[W:1]};
        B <= {s1_br[W:1], s1_bi[W:1]};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt  <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= out_xfer && (frame_cnt == CNT_MAX);
      if (out_xfer) begin
        frame_cnt <= frame_cnt + FRAME_LOG2'(1);
      end
    end
  end

endmodule

// File: doc/inv_butterfly_pipe.md
INV_BUTTERFLY_PIPE -- requirements
Module: inv_butterfly_pipe

Interface
REQ-001 Parameter W, default 12: width of each signed real/imag component; packed sample width is 2*W.
REQ-002 Parameter FRAME_LOG2, default 10: log2 of frame length; 1024 samples per frame at default.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  C1/C2 pair present on inputs.
REQ-006 in_ready  output  1  block accepts pair this cycle.
REQ-007 C1  input  2*W  butterfly sum output, packed {real[2W-1:W], imag[W-1:0]}, two's complement.
REQ-008 C2  input  2*W  butterfly difference output, same packing.
REQ-009 A  output  2*W  recovered first operand, same packing.
REQ-010 B  output  2*W  recovered second operand, same packing.
REQ-011 out_valid  output  1  A/B hold a valid result.
REQ-012 out_ready  input  1  downstream accepts A/B this cycle.
REQ-013 frame_cnt  output  FRAME_LOG2  count of output transfers in current frame.
REQ-014 frame_done  output  1  one-cycle pulse after the last transfer of a frame.

Function
REQ-015 Arithmetic per component: Ar=(C1r+C2r)>>>1, Ai=(C1i+C2i)>>>1, Br=(C1r-C2r)>>>1, Bi=(C1i-C2i)>>>1.
REQ-016 Sums/differences formed at W+1 bits sign-extended; arithmetic shift right by one (round toward minus infinity); result truncated to W bits, no saturation needed since the result always fits.
REQ-017 Two register stages: stage 1 holds the four W+1-bit sums/differences plus s1_valid; stage 2 holds shifted A/B plus out_valid.
REQ-018 Input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
REQ-019 Stage 2 loads when !out_valid || out_ready; stage 1 loads when !s1_valid || stage 2 loads.
REQ-020 in_ready = !s1_valid || stage-2 load condition (combinational path from out_ready permitted).
REQ-021 Latency: pair accepted in cycle N appears with out_valid high in cycle N+2 when no stall.
REQ-022 Throughput: one pair per cycle sustained while out_ready is held high.
REQ-023 Stall: while out_valid && !out_ready, A, B, and out_valid hold stable; stage 1 holds if full; no data lost or duplicated.
REQ-024 Bubbles: a stage advancing with no valid data below it clears its valid bit; data registers may retain old values.
REQ-025 frame_cnt increments by one on each output transfer; wraps from 2^FRAME_LOG2-1 to 0.
REQ-026 frame_done is registered: high for exactly one cycle following the transfer that wraps frame_cnt to 0; low otherwise.
REQ-027 Simultaneous input and output transfer in the same cycle with both stages full is legal and keeps the pipeline full.
REQ-028 Inputs are ignored when in_valid is low; C1/C2 may be X then.

Reset
REQ-029 While rst is high: s1_valid=0, out_valid=0, A=0, B=0, frame_cnt=0, frame_done=0, stage-1 data=0.
REQ-030 Reset asserted mid-operation discards all in-flight samples immediately, with no output transfer occurring.
REQ-031 in_ready is high in the first cycle after rst deasserts.

Verification
REQ-032 C1=0x00A004, C2=0x002FFE, out_ready=1 -> two cycles later A=0x006001, B=0x004003, out_valid=1 for one cycle.
REQ-033 Extremes: C1=0x7FF800, C2=0x7FF7FF -> A=0x7FFFFF, B=0x000800.
REQ-034 Stream 1024 random pairs with out_ready=1 -> 1024 outputs in order matching REQ-015, frame_cnt back to 0, frame_done high exactly once, one cycle after the 1024th transfer.
REQ-035 Random out_ready (50%) and in_valid (70%) over 3000 pairs -> output sequence identical to golden model; A/B stable during every stall; no drops or duplicates.
REQ-036 Fill both stages, hold out_ready=0 for 5 cycles -> in_ready=0 throughout, A/B unchanged; release -> two outputs on consecutive cycles.
REQ-037 Assert rst with both stages full and frame_cnt=37 -> out_valid=0, frame_cnt=0 immediately, before the next clock edge; no stale output after release.
